ones_frame_counter: RTL

//  Counts the '1' bits in a serial bit stream. Bits are grouped into frames of FRAME_LEN accepted bits.

---
 rtl/ones_frame_counter.sv | 93 +++++++++
 1 files changed

// File: rtl/ones_frame_counter.sv
// Tallies '1' bits over frames of FRAME_LEN accepted bits; result appears 1 cycle after the last accept.
// Backpressure: din_ready drops while a result waits in HOLD and returns the cycle after the res handshake.
module ones_frame_counter #(
    parameter int CNT_W     = 8,
    parameter int FRAME_LEN = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] res_count,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             overflow,
    output logic             busy
);

    localparam int IDX_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;

    logic             accept;
    logic             saturated;
    logic [CNT_W-1:0] count_nxt;
    logic [IDX_W-1:0] idx_nxt;

    assign accept    = din_valid && din_ready;
    assign saturated = (count == CNT_MAX);
    assign count_nxt = (din && !saturated) ? count + CNT_W'(1) : count;
    assign idx_nxt   = idx + IDX_W'(1);

    // IDLE and COUNT share the accept path: in IDLE count and idx are already zero,
    // and a FRAME_LEN of 1 falls straight through to HOLD on the first accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            count     <= '0;
            res_count <= '0;
            res_valid <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            din_ready <= 1'b1;
        end else begin
            case (state)
                IDLE, COUNT: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (din && saturated) begin
                            overflow <= 1'b1;
                        end
                        if (idx_nxt == LAST_IDX) begin
                            res_count <= count_nxt;
                            res_valid <= 1'b1;
                            count     <= '0;
                            idx       <= '0;
                            din_ready <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            count <= count_nxt;
                            idx   <= idx_nxt;
                            state <= COUNT;
                        end
                    end
                end
                HOLD: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        overflow  <= 1'b0;
                        busy      <= 1'b0;
                        din_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
